// File: rtl/ram_arbiter.sv
// Arbitrates one external RAM port between the buffered download write stream and the CPU.
// Fixed priority favours io writes; a burst counter bounds how long a pending CPU waits.
module ram_arbiter #(
   parameter int unsigned AW           = 25,
   parameter int unsigned DW           = 8,
   parameter int unsigned IO_BURST_MAX = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_io_wr,
   input  logic [AW-1:0] i_io_a,
   input  logic [DW-1:0] i_io_d,
   output logic          o_io_busy,
   output logic          o_io_overrun,
   input  logic          i_cpu_req,
   input  logic          i_cpu_we,
   input  logic [AW-1:0] i_cpu_a,
   input  logic [DW-1:0] i_cpu_d,
   output logic          o_cpu_ack,
   output logic [DW-1:0] o_cpu_q,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_a,
   output logic [DW-1:0] o_mem_d,
   input  logic          i_mem_ack,
   input  logic [DW-1:0] i_mem_q
);

   typedef enum logic [1:0] {StIdle, StIoAcc, StCpuAcc} state_t;

   localparam logic [3:0] BurstMax = 4'(IO_BURST_MAX);

   state_t        r_state, w_state_d;
   logic [AW-1:0] r_fifo_a [2];
   logic [DW-1:0] r_fifo_d [2];
   logic          r_wr_ptr, r_rd_ptr;
   logic [1:0]    r_count, w_count_d;
   logic [3:0]    r_burst, w_burst_d;
   logic          r_io_busy, r_io_overrun;
   logic          r_cpu_ack, w_cpu_ack_d;
   logic [DW-1:0] r_cpu_q, w_cpu_q_d;
   logic          r_mem_req, w_mem_req_d;
   logic          r_mem_we, w_mem_we_d;
   logic [AW-1:0] r_mem_a, w_mem_a_d;
   logic [DW-1:0] r_mem_d, w_mem_d_d;
   logic          w_push, w_pop, w_cpu_pending;

   // The head entry stays in the FIFO while its access is in flight.
   assign w_pop         = (r_state == StIoAcc) & i_mem_ack;
   assign w_push        = i_io_wr & ((r_count != 2'd2) | w_pop);
   assign w_count_d     = r_count + {1'b0, w_push} - {1'b0, w_pop};
   // Masking with cpu_ack stops a request the CPU has not yet withdrawn being served twice.
   assign w_cpu_pending = i_cpu_req & ~r_cpu_ack;

   always_comb begin
      w_state_d   = r_state;
      w_mem_req_d = r_mem_req;
      w_mem_we_d  = r_mem_we;
      w_mem_a_d   = r_mem_a;
      w_mem_d_d   = r_mem_d;
      w_burst_d   = r_burst;
      w_cpu_ack_d = 1'b0;
      w_cpu_q_d   = r_cpu_q;
      case (r_state)
         StIdle: begin
            if ((r_count != 2'd0) && (!w_cpu_pending || (r_burst < BurstMax))) begin
               w_state_d   = StIoAcc;
               w_mem_req_d = 1'b1;
               w_mem_we_d  = 1'b1;
               w_mem_a_d   = r_fifo_a[r_rd_ptr];
               w_mem_d_d   = r_fifo_d[r_rd_ptr];
               if (w_cpu_pending) begin
                  w_burst_d = (r_burst == 4'hF) ? r_burst : r_burst + 4'd1;
               end else begin
                  w_burst_d = 4'd0;
               end
            end else if (w_cpu_pending) begin
               w_state_d   = StCpuAcc;
               w_mem_req_d = 1'b1;
               w_mem_we_d  = i_cpu_we;
               w_mem_a_d   = i_cpu_a;
               w_mem_d_d   = i_cpu_d;
               w_burst_d   = 4'd0;
            end else begin
               w_mem_req_d = 1'b0;
            end
         end
         StIoAcc: begin
            if (i_mem_ack) begin
               w_mem_req_d = 1'b0;
               w_state_d   = StIdle;
            end
         end
         StCpuAcc: begin
            if (i_mem_ack) begin
               w_mem_req_d = 1'b0;
               w_state_d   = StIdle;
               w_cpu_ack_d = 1'b1;
               if (!r_mem_we) begin
                  w_cpu_q_d = i_mem_q;
               end
            end
         end
         default: begin
            w_state_d   = StIdle;
            w_mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_count      <= 2'd0;
         r_burst      <= 4'd0;
         r_io_busy    <= 1'b0;
         r_io_overrun <= 1'b0;
         r_cpu_ack    <= 1'b0;
         r_cpu_q      <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_a      <= '0;
         r_mem_d      <= '0;
      end else begin
         r_state   <= w_state_d;
         r_count   <= w_count_d;
         r_burst   <= w_burst_d;
         r_io_busy <= (w_count_d != 2'd0);
         r_cpu_ack <= w_cpu_ack_d;
         r_cpu_q   <= w_cpu_q_d;
         r_mem_req <= w_mem_req_d;
         r_mem_we  <= w_mem_we_d;
         r_mem_a   <= w_mem_a_d;
         r_mem_d   <= w_mem_d_d;
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         if (i_io_wr && !w_push) begin
            r_io_overrun <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_a[r_wr_ptr] <= i_io_a;
         r_fifo_d[r_wr_ptr] <= i_io_d;
      end
   end

   assign o_io_busy    = r_io_busy;
   assign o_io_overrun = r_io_overrun;
   assign o_cpu_ack    = r_cpu_ack;
   assign o_cpu_q      = r_cpu_q;
   assign o_mem_req    = r_mem_req;
   assign o_mem_we     = r_mem_we;
   assign o_mem_a      = r_mem_a;
   assign o_mem_d      = r_mem_d;

endmodule
